// File: rtl/seq_div_unsigned_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM encoding and default width.
package seq_div_unsigned_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_unsigned_if.sv
// Start/done handshake bundle for the divider, plus FSM/accumulator visibility for checkers.
interface seq_div_unsigned_if #(
  parameter int W = 4
);
  import seq_div_unsigned_pkg::*;

  // Handshake: a request is taken when start=1 and busy=0; the result is valid
  // from the cycle done pulses and is held until the next done.
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  state_t       dbg_state;
  logic [W:0]   dbg_acc;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state, dbg_acc
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state, dbg_acc
  );

endinterface

// File: rtl/seq_div_unsigned_ripple_sub.sv
// N-bit ripple-borrow subtractor (o_diff = i_a - i_b - i_bin) built from 1-bit full-subtractor cells.
module ripple_sub #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic [N-1:0] o_diff,
  output logic         o_bout
);

  logic [N:0] w_borrow;

  assign w_borrow[0] = i_bin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign o_diff[i]     = i_a[i] ^ i_b[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~i_a[i] & i_b[i]) | (w_borrow[i] & ~(i_a[i] ^ i_b[i]));
  end

  assign o_bout = w_borrow[N];

endmodule

// File: rtl/seq_div_unsigned.sv
// Restoring unsigned divider: one quotient bit per clock, start/done handshake, divide-by-zero flag.
module seq_div_unsigned
  import seq_div_unsigned_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_div_unsigned_if.slave     bus
);

  localparam int             CW         = $clog2(W + 1);
  localparam logic [CW-1:0]  COUNT_INIT = CW'(W);
  localparam logic [CW-1:0]  COUNT_ONE  = CW'(1);

  state_t        r_state;
  logic [W:0]    r_a;
  logic [W-1:0]  r_q;
  logic [W:0]    r_m;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_dbz;

  logic [W:0]    w_shift_a;
  logic [W:0]    w_diff;
  logic          w_bout;
  logic [W:0]    w_a_next;
  logic [W-1:0]  w_q_next;

  // Shift {A,Q} left one place; A's extra bit keeps the shifted partial remainder in range.
  assign w_shift_a = {r_a[W-1:0], r_q[W-1]};

  ripple_sub #(.N(W + 1)) u_trial_sub (
    .i_a    (w_shift_a),
    .i_b    (r_m),
    .i_bin  (1'b0),
    .o_diff (w_diff),
    .o_bout (w_bout)
  );

  // A borrow means the trial went negative: keep the shifted A and shift in a 0.
  assign w_a_next = w_bout ? w_shift_a : w_diff;
  assign w_q_next = {r_q[W-2:0], ~w_bout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= '0;
            r_q     <= bus.dividend;
            r_m     <= {1'b0, bus.divisor};
            r_count <= COUNT_INIT;
            if (bus.divisor == '0) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        S_RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_count <= r_count - COUNT_ONE;
          if (r_count == COUNT_ONE) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_a_next[W-1:0];
            r_dbz       <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_acc     = r_a;

endmodule

// File: tb/tb_seq_div_unsigned.sv
// Self-checking bench for seq_div_unsigned (W=4 main instance, W=8 side instance).
module tb_seq_div_unsigned;
  import seq_div_unsigned_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_div_unsigned_if #(.W(4)) bus ();
  seq_div_unsigned_if #(.W(8)) bus8 ();

  seq_div_unsigned #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seq_div_unsigned #(.W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int errors = 0;
  int checks = 0;

  // Expected {quotient, remainder, div_by_zero}
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q_m;
    logic [3:0] r_m;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (b == 4'd0) begin
      exp_q.push_back({4'hF, a, 1'b1});
    end else begin
      q_m = a / b;
      r_m = a % b;
      exp_q.push_back({q_m, r_m, 1'b0});
    end
  endtask

  // Called at the negedge where start was driven; edges counts clock edges from the sampling edge.
  task automatic wait_done(input string tag, input int exp_edges, input int exp_busy, input bit hold);
    int         edges;
    int         busy_n;
    bit         held_ok;
    logic [3:0] q0;
    logic [3:0] r0;
    logic [8:0] e;
    edges   = 1;
    busy_n  = 0;
    held_ok = 1'b1;
    q0      = bus.quotient;
    r0      = bus.remainder;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    while (!bus.done && edges < 64) begin
      if (hold) begin
        if (edges < 4) begin
          bus.dividend = 4'($urandom_range(0, 15));
          bus.divisor  = 4'($urandom_range(0, 15));
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.busy) busy_n++;
      if (bus.quotient !== q0 || bus.remainder !== r0) held_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
    bus.start = 1'b0;
    check({tag, " done"}, {31'b0, bus.done}, 32'd1);
    check({tag, " latency"}, edges, exp_edges);
    check({tag, " busy_cycles"}, busy_n, exp_busy);
    check({tag, " result_held"}, {31'b0, held_ok}, 32'd1);
    check({tag, " state"}, 32'(bus.dbg_state), 32'(S_DONE));
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " quotient"}, {28'b0, bus.quotient}, {28'b0, e[8:5]});
      check({tag, " remainder"}, {28'b0, bus.remainder}, {28'b0, e[4:1]});
      check({tag, " dbz"}, {31'b0, bus.div_by_zero}, {31'b0, e[0]});
    end
  endtask

  task automatic do_div(input string tag, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    issue(a, b);
    if (b == 4'd0) wait_done(tag, 1, 0, 1'b0);
    else           wait_done(tag, 5, 4, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, " done"}, {31'b0, bus.done}, 32'd0);
    check({tag, " quotient"}, {28'b0, bus.quotient}, 32'd0);
    check({tag, " remainder"}, {28'b0, bus.remainder}, 32'd0);
    check({tag, " dbz"}, {31'b0, bus.div_by_zero}, 32'd0);
    check({tag, " state"}, 32'(bus.dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    int edges8;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus8.start    = 1'b0;
    bus8.dividend = '0;
    bus8.divisor  = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    do_div("13/4", 4'd13, 4'd4);
    do_div("15/1", 4'd15, 4'd1);
    do_div("3/7", 4'd3, 4'd7);
    do_div("0/5", 4'd0, 4'd5);

    do_div("9/0", 4'd9, 4'd0);
    do_div("8/2", 4'd8, 4'd2);

    @(negedge clk);
    issue(4'd13, 4'd4);
    wait_done("hold_start", 5, 4, 1'b1);

    do_div("12/5", 4'd12, 4'd5);
    issue(4'd7, 4'd2);
    wait_done("b2b_7/2", 5, 4, 1'b0);

    @(negedge clk);
    issue(4'd13, 4'd4);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    do_div("6/3_after_reset", 4'd6, 4'd3);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div("exhaustive", 4'(a), 4'(b));
      end
    end

    @(negedge clk);
    bus8.start    = 1'b1;
    bus8.dividend = 8'd255;
    bus8.divisor  = 8'd16;
    edges8 = 1;
    @(negedge clk);
    bus8.start = 1'b0;
    while (!bus8.done && edges8 < 64) begin
      @(negedge clk);
      edges8++;
    end
    check("w8 done", {31'b0, bus8.done}, 32'd1);
    check("w8 latency", edges8, 32'd9);
    check("w8 quotient", {24'b0, bus8.quotient}, 32'd15);
    check("w8 remainder", {24'b0, bus8.remainder}, 32'd15);
    check("w8 dbz", {31'b0, bus8.div_by_zero}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
